// File: rtl/fifo_stream_reader_if.sv
// Read-port and stream-side signals of the FIFO stream reader.
// master = the reader block, slave = the FIFO/consumer environment around it.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        input  m_ready,
        output fifo_rd_en,
        output m_data,
        output m_valid,
        output m_last
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        output m_ready,
        input  fifo_rd_en,
        input  m_data,
        input  m_valid,
        input  m_last
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a non-FWFT FIFO into a framed valid/ready stream; first beat RD_LATENCY+1 cycles after the read.
// Credit-limited skid buffer of RD_LATENCY+1 words; reads stop in the same cycle the credits run out.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int PKT_LEN    = 16
) (
    input  logic clk,
    input  logic rst_n,
    fifo_stream_reader_if.master bus
);
    localparam int DEPTH  = RD_LATENCY + 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1) + 1;
    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [BEAT_W-1:0] beat_t;

    logic [DATA_WIDTH-1:0] buf_mem [DEPTH];
    ptr_t                  wr_ptr;
    ptr_t                  rd_ptr;
    cnt_t                  occ;
    logic [RD_LATENCY-1:0] pipe;
    beat_t                 beat;

    logic                  capture;
    logic                  pop;
    logic                  rd_issue;
    logic                  valid_q;
    logic                  last_q;
    logic [DATA_WIDTH-1:0] data_q;
    cnt_t                  in_flight;
    cnt_t                  credits;

    // DEPTH is 3 for RD_LATENCY=2, so wrap must be an explicit compare.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : ptr_t'(p + 1'b1);
    endfunction

    assign capture = pipe[RD_LATENCY-1];
    assign valid_q = (occ != '0);
    assign data_q  = buf_mem[rd_ptr];
    assign last_q  = valid_q && (beat == beat_t'(PKT_LEN - 1));
    assign pop     = valid_q && bus.m_ready;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            in_flight = in_flight + cnt_t'(pipe[i]);
        end
    end

    // A pop in this cycle frees a slot, which is what keeps full rate at DEPTH credits.
    assign credits  = occ + in_flight - cnt_t'(pop);
    assign rd_issue = rst_n && !bus.fifo_empty && (credits < cnt_t'(DEPTH));

    assign bus.fifo_rd_en = rd_issue;
    assign bus.m_valid    = valid_q;
    assign bus.m_data     = data_q;
    assign bus.m_last     = last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe[0] <= rd_issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (capture) begin
            buf_mem[wr_ptr] <= bus.fifo_dout;
            wr_ptr          <= ptr_inc(wr_ptr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else begin
            case ({capture, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat <= '0;
        end else if (pop) begin
            beat <= (beat == beat_t'(PKT_LEN - 1)) ? '0 : beat_t'(beat + 1'b1);
        end
    end

    overflow_guard: assert property (@(posedge clk) disable iff (!rst_n)
        !(capture && (occ == cnt_t'(DEPTH)) && !pop));

    credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (occ + in_flight) <= cnt_t'(DEPTH));

    stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (valid_q && !bus.m_ready) |=> (valid_q && $stable(data_q) && $stable(last_q)));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: three parameterisations, each fed by a behavioural non-FWFT FIFO.
module tb_fifo_stream_reader;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_stream_reader_if #(.DATA_WIDTH(8)) bus_a ();
    fifo_stream_reader_if #(.DATA_WIDTH(8)) bus_b ();
    fifo_stream_reader_if #(.DATA_WIDTH(8)) bus_c ();

    fifo_stream_reader #(.DATA_WIDTH(8), .RD_LATENCY(1), .PKT_LEN(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    fifo_stream_reader #(.DATA_WIDTH(8), .RD_LATENCY(2), .PKT_LEN(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    fifo_stream_reader #(.DATA_WIDTH(8), .RD_LATENCY(1), .PKT_LEN(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    logic [7:0] fmem [3][256];
    int         wr [3];
    logic       rdy [3];
    int         rd_a;
    int         rd_b;
    int         rd_c;
    logic [7:0] dout_a;
    logic [7:0] pre_b;
    logic [7:0] dout_b;
    logic [7:0] dout_c;

    // FIFO models: flushed synchronously while reset is held, 0xEE on the bus when not reading.
    assign bus_a.fifo_empty = (wr[0] == rd_a);
    assign bus_a.fifo_dout  = dout_a;
    assign bus_a.m_ready    = rdy[0];
    always @(posedge clk) begin
        if (!rst_n) rd_a <= wr[0];
        else if (bus_a.fifo_rd_en) rd_a <= rd_a + 1;
        dout_a <= bus_a.fifo_rd_en ? fmem[0][rd_a % 256] : 8'hEE;
    end

    assign bus_b.fifo_empty = (wr[1] == rd_b);
    assign bus_b.fifo_dout  = dout_b;
    assign bus_b.m_ready    = rdy[1];
    always @(posedge clk) begin
        if (!rst_n) rd_b <= wr[1];
        else if (bus_b.fifo_rd_en) rd_b <= rd_b + 1;
        pre_b  <= bus_b.fifo_rd_en ? fmem[1][rd_b % 256] : 8'hEE;
        dout_b <= pre_b;
    end

    assign bus_c.fifo_empty = (wr[2] == rd_c);
    assign bus_c.fifo_dout  = dout_c;
    assign bus_c.m_ready    = rdy[2];
    always @(posedge clk) begin
        if (!rst_n) rd_c <= wr[2];
        else if (bus_c.fifo_rd_en) rd_c <= rd_c + 1;
        dout_c <= bus_c.fifo_rd_en ? fmem[2][rd_c % 256] : 8'hEE;
    end

    int         sel;
    logic       obs_rd;
    logic       obs_vld;
    logic       obs_last;
    logic [7:0] obs_data;

    always_comb begin
        obs_rd   = bus_a.fifo_rd_en;
        obs_vld  = bus_a.m_valid;
        obs_last = bus_a.m_last;
        obs_data = bus_a.m_data;
        case (sel)
            1: begin
                obs_rd   = bus_b.fifo_rd_en;
                obs_vld  = bus_b.m_valid;
                obs_last = bus_b.m_last;
                obs_data = bus_b.m_data;
            end
            2: begin
                obs_rd   = bus_c.fifo_rd_en;
                obs_vld  = bus_c.m_valid;
                obs_last = bus_c.m_last;
                obs_data = bus_c.m_data;
            end
            default: ;
        endcase
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input int d, input logic [7:0] v);
        fmem[d][wr[d] % 256] = v;
        wr[d] = wr[d] + 1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // mode 0: ready always high; 1: 3 low / 2 high; 2: ready low in cycles 6..10 only.
    task automatic stream_check(input int d, input int n, input logic [7:0] base,
                                input int pkt, input int depth, input int mode);
        int         issued;
        int         popped;
        bit         started;
        logic       pv;
        logic       pr;
        logic       pl;
        logic [7:0] pd;
        issued  = 0;
        popped  = 0;
        started = 1'b0;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 8'h00;
        sel = d;
        for (int cyc = 0; cyc < 40 * n + 40 && popped < n; cyc++) begin
            @(negedge clk);
            case (mode)
                1:       rdy[d] = ((cyc % 5) >= 3);
                2:       rdy[d] = !(cyc >= 6 && cyc < 11);
                default: rdy[d] = 1'b1;
            endcase
            if (cyc == 0) begin
                for (int i = 0; i < n; i++) push(d, base + 8'(i));
            end
            #1;
            if (pv && !pr) begin
                chk("hold_valid", obs_vld, 1);
                chk("hold_data", obs_data, pd);
                chk("hold_last", obs_last, pl);
            end
            if (obs_vld && !started) begin
                started = 1'b1;
                chk("first_valid_cycle", cyc, depth);
            end else if (started && mode != 1) begin
                chk("no_bubble", obs_vld, 1);
            end
            if (mode == 2 && cyc >= 6 && cyc < 11) chk("stall_rd_en", obs_rd, 0);
            if (mode == 2 && cyc == 11) chk("resume_rd_en", obs_rd, 1);
            issued += int'(obs_rd);
            if (obs_vld && rdy[d]) begin
                chk("beat_data", obs_data, base + popped);
                chk("beat_last", obs_last, (popped % pkt) == pkt - 1);
                popped++;
            end
            chk("outstanding", (issued - popped) <= depth, 1);
            if (mode == 2 && cyc == 10) chk("stall_buffered", issued - popped, depth);
            pv = obs_vld; pr = rdy[d]; pd = obs_data; pl = obs_last;
        end
        chk("beat_count", popped, n);
        @(negedge clk);
        #1;
        chk("drained_valid", obs_vld, 0);
        chk("drained_rd_en", obs_rd, 0);
        rdy[d] = 1'b0;
    endtask

    typedef struct {
        bit       push;
        bit [7:0] wdat;
        bit       rdy;
        bit       e_rd;
        bit       e_vld;
        bit       chk_dat;
        bit [7:0] e_dat;
        bit       e_last;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          push  wdat   rdy   rd    vld   chkd  dat    last
        tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[5]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[6]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 1'b0};
        tbl[7]  = '{1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h10, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 1'b1};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h12, 1'b1};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h13, 1'b0};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

        rst_n = 1'b0;
        sel   = 0;
        for (int d = 0; d < 3; d++) rdy[d] = 1'b0;

        // Reset state, with dut_a's FIFO briefly non-empty so only rst_n holds the read off.
        @(negedge clk);
        push(0, 8'h99);
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #1;
            chk($sformatf("rst%0d_rd_en", d), obs_rd, 0);
            chk($sformatf("rst%0d_valid", d), obs_vld, 0);
            chk($sformatf("rst%0d_last", d), obs_last, 0);
            chk($sformatf("rst%0d_data", d), obs_data, 0);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word, then a short backpressured run on RD_LATENCY=1 / PKT_LEN=4.
        sel = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (tbl[k].push) push(0, tbl[k].wdat);
            rdy[0] = tbl[k].rdy;
            #1;
            chk($sformatf("vec%0d_rd_en", k), obs_rd, tbl[k].e_rd);
            chk($sformatf("vec%0d_valid", k), obs_vld, tbl[k].e_vld);
            if (tbl[k].chk_dat) chk($sformatf("vec%0d_data", k), obs_data, tbl[k].e_dat);
            chk($sformatf("vec%0d_last", k), obs_last, tbl[k].e_last);
        end

        apply_reset();
        stream_check(0, 16, 8'h00, 4, 2, 0);
        apply_reset();
        stream_check(0, 16, 8'h80, 4, 2, 1);
        apply_reset();
        stream_check(1, 8, 8'h30, 4, 3, 2);

        // Reset with two reads in flight and beat = 2 on the RD_LATENCY=2 instance.
        apply_reset();
        sel    = 1;
        rdy[1] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) push(1, 8'h50 + 8'(i));
        repeat (5) @(negedge clk);
        #1;
        chk("pre_reset_valid", obs_vld, 1);
        chk("pre_reset_data", obs_data, 8'h52);
        chk("pre_reset_last", obs_last, 0);
        chk("pre_reset_rd_en", obs_rd, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_valid", obs_vld, 0);
        chk("mid_reset_last", obs_last, 0);
        chk("mid_reset_rd_en", obs_rd, 0);
        chk("mid_reset_data", obs_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        rdy[1] = 1'b0;
        stream_check(1, 4, 8'h60, 4, 3, 0);

        apply_reset();
        stream_check(2, 3, 8'h70, 1, 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
